// File: rtl/fetchq_pkg.sv
// Shared types and predecode helpers for the fetch queue.
// Lane storage is FQ_XLEN wide; instantiate fetch_queue with XLEN == FQ_XLEN.
package fetchq_pkg;

  localparam int FQ_XLEN = 32;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [FQ_XLEN-1:0] addr;
    logic [FQ_XLEN-1:0] data;
  } fetch_lane_t;

  function automatic logic is_ctrl_op(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// I-cache, redirect and dispatch signals of the fetch queue.
// dq_is_ctrl exists only when FETCHQ_PREDECODE_EN is defined.
interface fetch_queue_if #(
  parameter int XLEN           = 32,
  parameter int FETCH_WIDTH    = 3,
  parameter int DISPATCH_WIDTH = 3,
  parameter int DEPTH          = 16
);
  localparam int FC_W  = $clog2(FETCH_WIDTH + 1);
  localparam int DC_W  = $clog2(DISPATCH_WIDTH + 1);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [FETCH_WIDTH-1:0][XLEN-1:0]    ic_addr;
  logic [FETCH_WIDTH-1:0][XLEN-1:0]    ic_data;
  logic [FETCH_WIDTH-1:0]              ic_valid;
  logic [XLEN-1:0]                     fetch_pc;
  logic [FC_W-1:0]                     fetch_count;
  logic                                redirect_valid;
  logic [XLEN-1:0]                     redirect_pc;
  logic [DISPATCH_WIDTH-1:0][XLEN-1:0] dq_addr;
  logic [DISPATCH_WIDTH-1:0][XLEN-1:0] dq_data;
  logic [DISPATCH_WIDTH-1:0]           dq_valid;
  logic [DC_W-1:0]                     dispatch_count;
  logic [OCC_W-1:0]                    occupancy;
`ifdef FETCHQ_PREDECODE_EN
  logic [DISPATCH_WIDTH-1:0]           dq_is_ctrl;
`endif

  modport slave (
    input  ic_addr, ic_data, ic_valid, redirect_valid, redirect_pc, dispatch_count,
    output fetch_pc, fetch_count, dq_addr, dq_data, dq_valid, occupancy
`ifdef FETCHQ_PREDECODE_EN
    , output dq_is_ctrl
`endif
  );

  modport master (
    output ic_addr, ic_data, ic_valid, redirect_valid, redirect_pc, dispatch_count,
    input  fetch_pc, fetch_count, dq_addr, dq_data, dq_valid, occupancy
`ifdef FETCHQ_PREDECODE_EN
    , input dq_is_ctrl
`endif
  );

endinterface

// File: rtl/fetchq_prefix_count.sv
// Length of the contiguous run of set bits from bit 0, capped at limit.
module fetchq_prefix_count #(
  parameter int N = 3,
  parameter int W = 4
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count
);
  logic [W-1:0] run_len;
  logic         run;

  always_comb begin
    run_len = '0;
    run     = 1'b1;
    for (int i = 0; i < N; i++) begin
      run = run & valid[i];
      if (run) run_len = run_len + W'(1);
    end
    count = (run_len < limit) ? run_len : limit;
  end

endmodule

// File: rtl/fetch_queue.sv
// Circular fetch queue between I-cache and dispatch with redirect flush.
// Define FETCHQ_PREDECODE_EN to store a per-entry control-flow flag and expose dq_is_ctrl.
module fetch_queue
  import fetchq_pkg::*;
#(
  parameter int              XLEN           = FQ_XLEN,
  parameter int              FETCH_WIDTH    = 3,
  parameter int              DISPATCH_WIDTH = 3,
  parameter int              DEPTH          = 16,
  parameter logic [XLEN-1:0] RESET_PC       = '0
) (
  input logic           clock,
  input logic           reset_n,
  input logic           enable,
  fetch_queue_if.slave  bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int FC_W   = $clog2(FETCH_WIDTH + 1);
  localparam int FC_MAX = (FETCH_WIDTH < DEPTH) ? FETCH_WIDTH : DEPTH;

  logic [PTR_W-1:0] head, tail;
  logic [OCC_W-1:0] occ, occ_nxt, free, limit, acc_raw, acc, pop, dc, room;
  logic [XLEN-1:0]  fetch_pc, pc_nxt;
  logic [FC_W-1:0]  fetch_count, fc_nxt;
  logic             go;
  fetch_lane_t      mem [DEPTH];

  logic [DISPATCH_WIDTH-1:0][XLEN-1:0] dq_addr, dq_data;
  logic [DISPATCH_WIDTH-1:0]           dq_valid;

  // free uses start-of-cycle occupancy: a same-cycle pop does not make room
  assign free  = OCC_W'(DEPTH) - occ;
  assign limit = (OCC_W'(fetch_count) < free) ? OCC_W'(fetch_count) : free;

  fetchq_prefix_count #(.N(FETCH_WIDTH), .W(OCC_W)) u_prefix (
    .valid (bus.ic_valid),
    .limit (limit),
    .count (acc_raw)
  );

  always_comb begin
    go      = enable && !bus.redirect_valid;
    acc     = go ? acc_raw : '0;
    dc      = OCC_W'(bus.dispatch_count);
    pop     = go ? ((dc < occ) ? dc : occ) : '0;
    occ_nxt = occ + acc - pop;
    room    = OCC_W'(DEPTH) - occ_nxt;
    fc_nxt  = (room < OCC_W'(FETCH_WIDTH)) ? FC_W'(room) : FC_W'(FETCH_WIDTH);
    pc_nxt  = fetch_pc + (XLEN'(acc) << 2);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head        <= '0;
      tail        <= '0;
      occ         <= '0;
      fetch_pc    <= RESET_PC;
      fetch_count <= FC_W'(FC_MAX);
    end else if (bus.redirect_valid) begin
      head        <= '0;
      tail        <= '0;
      occ         <= '0;
      fetch_pc    <= bus.redirect_pc;
      fetch_count <= FC_W'(FC_MAX);
    end else if (enable) begin
      head        <= head + PTR_W'(pop);
      tail        <= tail + PTR_W'(acc);
      occ         <= occ_nxt;
      fetch_pc    <= pc_nxt;
      fetch_count <= fc_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < FETCH_WIDTH; i++)
        if (OCC_W'(i) < acc)
          mem[tail + PTR_W'(i)] <= '{addr: bus.ic_addr[i], data: bus.ic_data[i]};
    end
  end

  always_comb begin
    dq_valid = '0;
    dq_addr  = '0;
    dq_data  = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (OCC_W'(i) < occ) begin
        dq_valid[i] = 1'b1;
        dq_addr[i]  = mem[head + PTR_W'(i)].addr;
        dq_data[i]  = mem[head + PTR_W'(i)].data;
      end
    end
  end

`ifdef FETCHQ_PREDECODE_EN
  logic [DEPTH-1:0]          ctrl;
  logic [DISPATCH_WIDTH-1:0] dq_ctrl;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl <= '0;
    end else if (bus.redirect_valid) begin
      ctrl <= '0;
    end else begin
      for (int i = 0; i < FETCH_WIDTH; i++)
        if (OCC_W'(i) < acc)
          ctrl[tail + PTR_W'(i)] <= is_ctrl_op(bus.ic_data[i][6:0]);
    end
  end

  always_comb begin
    dq_ctrl = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      if (OCC_W'(i) < occ) dq_ctrl[i] = ctrl[head + PTR_W'(i)];
  end

  assign bus.dq_is_ctrl = dq_ctrl;
`endif

  assign bus.fetch_pc    = fetch_pc;
  assign bus.fetch_count = fetch_count;
  assign bus.occupancy   = occ;
  assign bus.dq_valid    = dq_valid;
  assign bus.dq_addr     = dq_addr;
  assign bus.dq_data     = dq_data;

  // dispatch may never consume more lanes than are shown
  a_dispatch_le_occ: assert property (@(posedge clock) disable iff (!reset_n)
    (enable && !bus.redirect_valid) |-> (OCC_W'(bus.dispatch_count) <= occ));

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-width instruction buffer: a circular queue between the I-cache and dispatch.
- Fetch and dispatch widths are independent, and depth is configurable.
- Dispatch uses a count-based in-order pop, replacing the per-lane re-show scheme.
- Generates the next fetch PC/count toward the I-cache and flushes on a redirect (branch/exception).

Parameters:
- XLEN, 32, address/instruction width
- FETCH_WIDTH, 3, max lanes returned by the I-cache per cycle
- DISPATCH_WIDTH, 3, max lanes presented to dispatch per cycle
- DEPTH, 16, queue entries; power of two, >= max(FETCH_WIDTH, DISPATCH_WIDTH)
- RESET_PC, 0, fetch PC after reset

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  low: hold all state (redirect still honoured)
- ic_addr  in  FETCH_WIDTH*XLEN  per-lane PC from I-cache
- ic_data  in  FETCH_WIDTH*XLEN  per-lane instruction
- ic_valid  in  FETCH_WIDTH  per-lane valid, same cycle as request
- fetch_pc  out  XLEN  registered PC requested from I-cache
- fetch_count  out  clog2(FETCH_WIDTH+1)  registered lanes requested
- redirect_valid  in  1  flush and refetch
- redirect_pc  in  XLEN  refetch target
- dq_addr  out  DISPATCH_WIDTH*XLEN  PCs of oldest entries
- dq_data  out  DISPATCH_WIDTH*XLEN  instructions of oldest entries
- dq_valid  out  DISPATCH_WIDTH  lane i valid iff i < occupancy
- dispatch_count  in  clog2(DISPATCH_WIDTH+1)  lanes consumed this cycle, in order from lane 0
- occupancy  out  clog2(DEPTH)+1  registered entry count

Behaviour:
- Reset is asynchronous, active-low, and applies to all registers:
  - head = tail = 0, occupancy = 0, storage valid cleared
  - fetch_pc = RESET_PC, fetch_count = min(FETCH_WIDTH, DEPTH)
  - dq_* driven 0
- I-cache interface is zero-latency: ic_* respond in the same cycle to the registered fetch_pc/fetch_count.
- Push rule:
  - Accept the contiguous prefix of ic_valid starting at lane 0; stop at the first 0, ignoring later 1s.
  - Cap the prefix at fetch_count and at free = DEPTH - occupancy (start-of-cycle value, no same-cycle pop bypass).
  - Write accepted lanes to tail, tail+1, ... (mod DEPTH); tail += acc.
  - Lanes rejected for lack of space are dropped and refetched, because fetch_pc advances only by the accepted count.
- fetch_pc_next = fetch_pc + 4*acc.
- fetch_count_next = min(FETCH_WIDTH, DEPTH - occupancy_next).
- Dispatch view is combinational from registers: lane i shows entry head+i (mod DEPTH), and dq_valid[i] = (i < occupancy).
- Pop:
  - pop = min(dispatch_count, occupancy); head += pop.
  - dispatch_count > occupancy is a protocol error; clamp it and fire the assertion.
- occupancy_next = occupancy + acc - pop. Push and pop in the same cycle are both honoured.
- Full (occupancy == DEPTH): fetch_count = 0, acc = 0, pop still allowed.
- Empty: dq_valid all 0, pop = 0.
- Pointers are clog2(DEPTH) bits and wrap naturally. Occupancy disambiguates full from empty.
- Redirect (highest priority, regardless of enable):
  - Next edge: head = tail = occupancy = 0, fetch_pc = redirect_pc, fetch_count = min(FETCH_WIDTH, DEPTH).
  - Same-cycle ic_* and dispatch_count are ignored; entries shown that cycle are discarded.
- enable low with no redirect: every register holds; acc and pop are treated as 0.
- Async reset asserted mid-operation discards everything immediately; the first fetch after release is at RESET_PC.

Optional Feature:
- Macro: FETCHQ_PREDECODE_EN
- Defined:
  - Each entry stores an is_ctrl bit computed at push: opcode[6:0] in {1100011, 1101111, 1100111}.
  - Extra output dq_is_ctrl, DISPATCH_WIDTH wide, aligned with dq_valid and 0 where invalid.
  - Reset and redirect clear it.
- Undefined: the port and storage are absent; behaviour is otherwise identical.

Decomposition:
- Package fetchq_pkg:
  - fetch_lane_t struct {addr, data}
  - helper function is_ctrl_op
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR
- Sub-module fetchq_prefix_count (combinational): contiguous-prefix length of ic_valid, capped by a limit input. Reused wherever lane-valid compaction is needed.

Test Plan:
- Reset and basic fetch (DEPTH=8, FW=3, DW=3):
  - Release reset_n; respond ic_valid=111 at PC 0,4,8 with dispatch_count=0 → next cycle occupancy=3, fetch_pc=0x0C, fetch_count=3, dq_valid=111.
- Fill to full:
  - Keep responding 111 with no dispatch → occupancy 3,6,8.
  - The third response accepts 2 lanes; fetch_pc=0x20, fetch_count=0, lane at 0x20 refetched later.
- Prefix and pop:
  - ic_valid=101 → acc=1 only.
  - Simultaneously dispatch_count=2 with occupancy=5 → occupancy=4, head advances 2, dq_addr[0] = old entry 2.
- Wrap-around:
  - Sustain push 3 / pop 3 for 20 cycles → dq_addr sequence strictly +4 per lane with no gaps or duplicates across the pointer wrap.
- Redirect:
  - At occupancy=6, assert redirect_valid, redirect_pc=0x400, with ic_valid=111 and dispatch_count=3 → next cycle occupancy=0, dq_valid=000, fetch_pc=0x400, fetch_count=3.
  - Redirect with enable=0 gives the same result.
- Async reset and predecode:
  - Assert reset_n low mid-cycle → outputs reset before the next clock edge.
  - With FETCHQ_PREDECODE_EN, push 0x0000006F (JAL) then 0x00000013 (ADDI) → dq_is_ctrl=01.
